mult_delay_pipe: RTL and testbench

- Parametrised replacement for the fixed five-stage chain of mult latches (exe→mult1…mult5).
- Carries write data, destination address, write enable, instruction and PC through NUM_STAGES registered stages to writeback.
- Adds pipeline stall and flush.
- Adds a built-in two-port bypass lookup that returns forwarded data, or a pending flag when the youngest producer's result is not ready yet.

---
 rtl/mult_delay_pipe_pkg.sv | 19 +
 rtl/mult_delay_pipe_bypass_lookup.sv | 49 ++++
 rtl/mult_delay_pipe.sv | 140 ++++++++++++++
 tb/tb_mult_delay_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_delay_pipe_pkg.sv
// Shared types and constants for the multiply writeback delay pipeline.
// The stage-entry struct is shared with the other fixed-width pipeline latches.
package mult_delay_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
    } stage_entry_t;

endpackage

// File: rtl/mult_delay_pipe_bypass_lookup.sv
// Youngest-producer search over the delay stages for one bypass query port.
// Index 0 is stage 1 (youngest); a match not yet ready reports pending instead of data.
module mult_delay_pipe_bypass_lookup #(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned READY_STAGE = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic [NUM_STAGES-1:0]             stage_valid_i,
    input  logic [NUM_STAGES-1:0]             stage_wr_en_i,
    input  logic [NUM_STAGES-1:0][ADDR_W-1:0] stage_addr_i,
    input  logic [NUM_STAGES-1:0][DATA_W-1:0] stage_data_i,
    input  logic [ADDR_W-1:0]                 query_i,
    output logic                              hit_o,
    output logic [DATA_W-1:0]                 data_o,
    output logic                              pending_o
);

    import mult_delay_pipe_pkg::*;

    logic              found;
    logic              win_ready;
    logic [DATA_W-1:0] win_data;
    logic              query_nz;

    assign query_nz = (query_i != ADDR_W'(REG_ZERO));

    // Walk oldest to youngest so the last match seen is the youngest producer.
    always_comb begin
        found     = 1'b0;
        win_ready = 1'b0;
        win_data  = '0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            if (stage_valid_i[i] && stage_wr_en_i[i] && query_nz &&
                (stage_addr_i[i] == query_i)) begin
                found     = 1'b1;
                win_ready = ((i + 1) >= int'(READY_STAGE));
                win_data  = stage_data_i[i];
            end
        end
    end

    always_comb begin
        hit_o     = found & win_ready;
        pending_o = found & ~win_ready;
        data_o    = hit_o ? win_data : '0;
    end

endmodule

// File: rtl/mult_delay_pipe.sv
// Parametrised multiply-result delay pipeline to writeback, with stall, flush
// and a two-port bypass lookup over the in-flight entries.
module mult_delay_pipe #(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned READY_STAGE = 5,
    parameter int unsigned DATA_W      = mult_delay_pipe_pkg::DATA_W,
    parameter int unsigned ADDR_W      = mult_delay_pipe_pkg::ADDR_W
) (
    input  logic                             clk_i,
    input  logic                             rsn_i,
    input  logic                             in_valid_i,
    input  logic [DATA_W-1:0]                in_data_i,
    input  logic [ADDR_W-1:0]                in_addr_i,
    input  logic                             in_wr_en_i,
    input  logic [DATA_W-1:0]                in_instr_i,
    input  logic [DATA_W-1:0]                in_pc_i,
    input  logic                             stall_i,
    input  logic                             flush_i,
    input  logic [ADDR_W-1:0]                query_a_addr_i,
    input  logic [ADDR_W-1:0]                query_b_addr_i,
    output logic                             out_valid_o,
    output logic                             out_wr_en_o,
    output logic [DATA_W-1:0]                out_data_o,
    output logic [ADDR_W-1:0]                out_addr_o,
    output logic [DATA_W-1:0]                out_instr_o,
    output logic [DATA_W-1:0]                out_pc_o,
    output logic                             hit_a_o,
    output logic [DATA_W-1:0]                data_a_o,
    output logic                             pending_a_o,
    output logic                             hit_b_o,
    output logic [DATA_W-1:0]                data_b_o,
    output logic                             pending_b_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]  count_o,
    output logic                             busy_o
);

    localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned LAST  = NUM_STAGES - 1;

    // Index 0 holds stage 1, index LAST holds the writeback stage.
    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0]             wr_en_q, wr_en_d;
    logic [NUM_STAGES-1:0][ADDR_W-1:0] addr_q,  addr_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] data_q,  data_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] instr_q, instr_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] pc_q,    pc_d;

    logic [CNT_W-1:0] cnt;

    // Flush only kills valid bits; payload fields are left stale on purpose.
    always_comb begin
        valid_d = valid_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (!stall_i) begin
            valid_d = {valid_q[NUM_STAGES-2:0], in_valid_i};
            wr_en_d = {wr_en_q[NUM_STAGES-2:0], in_wr_en_i};
            addr_d  = {addr_q[NUM_STAGES-2:0],  in_addr_i};
            data_d  = {data_q[NUM_STAGES-2:0],  in_data_i};
            instr_d = {instr_q[NUM_STAGES-2:0], in_instr_i};
            pc_d    = {pc_q[NUM_STAGES-2:0],    in_pc_i};
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= '0;
            wr_en_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // Gating the strobe with stall/flush yields one write per entry however long it is held.
    always_comb begin
        out_valid_o = valid_q[LAST];
        out_wr_en_o = valid_q[LAST] & wr_en_q[LAST] & ~stall_i & ~flush_i;
        out_data_o  = data_q[LAST];
        out_addr_o  = addr_q[LAST];
        out_instr_o = instr_q[LAST];
        out_pc_o    = pc_q[LAST];
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            cnt = cnt + CNT_W'(valid_q[i]);
        end
    end

    assign count_o = cnt;
    assign busy_o  = (cnt != '0);

    mult_delay_pipe_bypass_lookup #(
        .NUM_STAGES  (NUM_STAGES),
        .READY_STAGE (READY_STAGE),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W)
    ) u_bypass_a (
        .stage_valid_i (valid_q),
        .stage_wr_en_i (wr_en_q),
        .stage_addr_i  (addr_q),
        .stage_data_i  (data_q),
        .query_i       (query_a_addr_i),
        .hit_o         (hit_a_o),
        .data_o        (data_a_o),
        .pending_o     (pending_a_o)
    );

    mult_delay_pipe_bypass_lookup #(
        .NUM_STAGES  (NUM_STAGES),
        .READY_STAGE (READY_STAGE),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W)
    ) u_bypass_b (
        .stage_valid_i (valid_q),
        .stage_wr_en_i (wr_en_q),
        .stage_addr_i  (addr_q),
        .stage_data_i  (data_q),
        .query_i       (query_b_addr_i),
        .hit_o         (hit_b_o),
        .data_o        (data_b_o),
        .pending_o     (pending_b_o)
    );

endmodule

// File: tb/tb_mult_delay_pipe.sv
// Bench for mult_delay_pipe: scoreboard on writebacks plus per-scenario bypass/stall/flush checks.
// A second instance with READY_STAGE=1 exercises early forwarding.
module tb_mult_delay_pipe;

    import mult_delay_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rsn;
    logic        in_valid, in_wr_en, stall, flush;
    logic [31:0] in_data, in_instr, in_pc;
    logic [4:0]  in_addr, query_a, query_b;

    logic        o_valid, o_wr_en, hit_a, pend_a, hit_b, pend_b, busy;
    logic [31:0] o_data, o_instr, o_pc, data_a, data_b;
    logic [4:0]  o_addr;
    logic [2:0]  count;

    logic        r_valid, r_wr_en, r_hit_a, r_pend_a, r_hit_b, r_pend_b, r_busy;
    logic [31:0] r_data, r_instr, r_pc, r_data_a, r_data_b;
    logic [4:0]  r_addr;
    logic [2:0]  r_count;

    logic [174:0] dut_outs, r_outs;
    assign dut_outs = {o_valid, o_wr_en, o_data, o_addr, o_instr, o_pc, hit_a, data_a, pend_a,
                       hit_b, data_b, pend_b, count, busy};
    assign r_outs   = {r_valid, r_wr_en, r_data, r_addr, r_instr, r_pc, r_hit_a, r_data_a,
                       r_pend_a, r_hit_b, r_data_b, r_pend_b, r_count, r_busy};

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int unsigned pc_ctr = 32'h1000;
    stage_entry_t exp_q[$];
    stage_entry_t mon_e;

    always #5 clk = ~clk;

    mult_delay_pipe #(
        .NUM_STAGES(5), .READY_STAGE(5), .DATA_W(32), .ADDR_W(5)
    ) dut (
        .clk_i(clk), .rsn_i(rsn), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_addr_i(in_addr), .in_wr_en_i(in_wr_en), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .stall_i(stall), .flush_i(flush), .query_a_addr_i(query_a), .query_b_addr_i(query_b),
        .out_valid_o(o_valid), .out_wr_en_o(o_wr_en), .out_data_o(o_data),
        .out_addr_o(o_addr), .out_instr_o(o_instr), .out_pc_o(o_pc),
        .hit_a_o(hit_a), .data_a_o(data_a), .pending_a_o(pend_a),
        .hit_b_o(hit_b), .data_b_o(data_b), .pending_b_o(pend_b),
        .count_o(count), .busy_o(busy)
    );

    mult_delay_pipe #(
        .NUM_STAGES(5), .READY_STAGE(1), .DATA_W(32), .ADDR_W(5)
    ) dut_r1 (
        .clk_i(clk), .rsn_i(rsn), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_addr_i(in_addr), .in_wr_en_i(in_wr_en), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .stall_i(stall), .flush_i(flush), .query_a_addr_i(query_a), .query_b_addr_i(query_b),
        .out_valid_o(r_valid), .out_wr_en_o(r_wr_en), .out_data_o(r_data),
        .out_addr_o(r_addr), .out_instr_o(r_instr), .out_pc_o(r_pc),
        .hit_a_o(r_hit_a), .data_a_o(r_data_a), .pending_a_o(r_pend_a),
        .hit_b_o(r_hit_b), .data_b_o(r_data_b), .pending_b_o(r_pend_b),
        .count_o(r_count), .busy_o(r_busy)
    );

    // Scoreboard: every writeback strobe must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (rsn && o_wr_en) begin
            wr_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         o_addr, o_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_addr, o_data, o_instr, o_pc} !==
                    {mon_e.addr, mon_e.data, mon_e.instr, mon_e.pc}) begin
                    fails++;
                    $display("FAIL wb_entry: got a=%0d d=%h i=%h pc=%h, expected a=%0d d=%h i=%h pc=%h",
                             o_addr, o_data, o_instr, o_pc,
                             mon_e.addr, mon_e.data, mon_e.instr, mon_e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] d, input logic [4:0] a, input logic we);
        stage_entry_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        in_wr_en = we;
        in_instr = d ^ 32'hA5A5_0000;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 4;
        e = '{valid: 1'b1, wr_en: we, addr: a, data: d, instr: in_instr, pc: in_pc};
        if (we) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        in_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (dut_outs !== '0) begin
            fails++;
            $display("FAIL reset_outs: got %h, expected 0", dut_outs);
        end
        tests++;
        if (r_outs !== '0) begin
            fails++;
            $display("FAIL reset_outs_r1: got %h, expected 0", r_outs);
        end
        @(negedge clk);
        rsn = 1'b1;
    endtask

    task automatic test_single();
        logic exp_we;
        accept(32'hDEADBEEF, 5'd7, 1'b1);
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL single_count1: got %0d, expected 1", count);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_we = (c == 4);
            tests++;
            if (o_wr_en !== exp_we) begin
                fails++;
                $display("FAIL single_wr_en_c%0d: got %b, expected %b", c, o_wr_en, exp_we);
            end
            if (c == 4) begin
                tests++;
                if (o_data !== 32'hDEADBEEF) begin
                    fails++;
                    $display("FAIL single_data: got %h, expected deadbeef", o_data);
                end
            end
        end
        tests++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_count0: got count=%0d busy=%b, expected 0/0", count, busy);
        end
    endtask

    task automatic test_pending_hit();
        query_a = 5'd3;
        query_b = 5'd3;
        accept(32'h0000_1234, 5'd3, 1'b1);
        tick();
        tests++;
        if ({pend_a, hit_a, data_a} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL pend_stage2: got p=%b h=%b d=%h, expected p=1 h=0 d=0",
                     pend_a, hit_a, data_a);
        end
        tests++;
        if ({r_pend_a, r_hit_a, r_data_a} !== {1'b0, 1'b1, 32'h1234}) begin
            fails++;
            $display("FAIL r1_hit_stage2: got p=%b h=%b d=%h, expected p=0 h=1 d=1234",
                     r_pend_a, r_hit_a, r_data_a);
        end
        repeat (3) tick();
        tests++;
        if ({pend_a, hit_a, data_a} !== {1'b0, 1'b1, 32'h1234}) begin
            fails++;
            $display("FAIL hit_stage5_a: got p=%b h=%b d=%h, expected p=0 h=1 d=1234",
                     pend_a, hit_a, data_a);
        end
        tests++;
        if ({pend_b, hit_b, data_b} !== {1'b0, 1'b1, 32'h1234}) begin
            fails++;
            $display("FAIL hit_stage5_b: got p=%b h=%b d=%h, expected p=0 h=1 d=1234",
                     pend_b, hit_b, data_b);
        end
        tick();
        tests++;
        if ({pend_a, hit_a, data_a} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL drained_a: got p=%b h=%b d=%h, expected all 0", pend_a, hit_a, data_a);
        end
        query_a = 5'd0;
        query_b = 5'd0;
    endtask

    task automatic test_youngest();
        query_a = 5'd4;
        query_b = 5'd9;
        accept(32'h11, 5'd4, 1'b1);
        repeat (3) tick();
        accept(32'h22, 5'd4, 1'b1);
        tests++;
        if ({pend_a, hit_a, data_a} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL youngest_pending: got p=%b h=%b d=%h, expected p=1 h=0 d=0",
                     pend_a, hit_a, data_a);
        end
        tests++;
        if ({r_pend_a, r_hit_a, r_data_a} !== {1'b0, 1'b1, 32'h22}) begin
            fails++;
            $display("FAIL youngest_r1: got p=%b h=%b d=%h, expected p=0 h=1 d=22",
                     r_pend_a, r_hit_a, r_data_a);
        end
        tests++;
        if ({pend_b, hit_b, data_b} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL nomatch_b: got p=%b h=%b d=%h, expected all 0", pend_b, hit_b, data_b);
        end
        query_a = 5'd0;
        query_b = 5'd0;
        repeat (5) tick();
    endtask

    task automatic test_stall();
        int wr_before;
        accept(32'hCAFE0001, 5'd10, 1'b1);
        repeat (4) tick();
        wr_before = wr_count;
        stall    = 1'b1;
        in_valid = 1'b1;
        in_wr_en = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        in_addr  = 5'd11;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) tick();
            tests++;
            if ({o_valid, o_wr_en, o_data} !== {1'b1, 1'b0, 32'hCAFE0001}) begin
                fails++;
                $display("FAIL stall_hold_c%0d: got v=%b we=%b d=%h, expected v=1 we=0 d=cafe0001",
                         c, o_valid, o_wr_en, o_data);
            end
        end
        tick();
        stall    = 1'b0;
        in_valid = 1'b0;
        in_wr_en = 1'b0;
        #1;
        tests++;
        if ({o_wr_en, o_data} !== {1'b1, 32'hCAFE0001}) begin
            fails++;
            $display("FAIL stall_release: got we=%b d=%h, expected we=1 d=cafe0001", o_wr_en, o_data);
        end
        tick();
        tests++;
        if ({o_valid, count} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL stall_after: got v=%b count=%0d, expected v=0 count=0", o_valid, count);
        end
        tests++;
        if (wr_count - wr_before !== 1) begin
            fails++;
            $display("FAIL stall_write_count: got %0d writes, expected 1", wr_count - wr_before);
        end
    endtask

    task automatic test_flush_stall();
        for (int i = 0; i < 5; i++) accept(32'h100 + i, 5'(i + 1), 1'b1);
        tests++;
        if ({count, o_valid} !== {3'd5, 1'b1}) begin
            fails++;
            $display("FAIL full_count: got count=%0d v=%b, expected 5/1", count, o_valid);
        end
        flush    = 1'b1;
        stall    = 1'b1;
        in_valid = 1'b1;
        in_wr_en = 1'b1;
        exp_q.delete();
        #1;
        tests++;
        if (o_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall_wr: got %b, expected 0", o_wr_en);
        end
        tick();
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        in_wr_en = 1'b0;
        #1;
        tests++;
        if ({count, o_valid, busy, o_wr_en} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL flush_result: got count=%0d v=%b busy=%b we=%b, expected all 0",
                     count, o_valid, busy, o_wr_en);
        end
        tick();
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL flush_no_capture: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_zero_reset();
        query_a = 5'd0;
        query_b = 5'd5;
        accept(32'h77, 5'd0, 1'b1);
        accept(32'h55, 5'd5, 1'b1);
        tests++;
        if ({r_hit_a, r_pend_a, pend_a, hit_a} !== 4'b0000) begin
            fails++;
            $display("FAIL zero_reg: got r1 h=%b p=%b, dut h=%b p=%b, expected all 0",
                     r_hit_a, r_pend_a, hit_a, pend_a);
        end
        tests++;
        if ({r_hit_b, r_data_b} !== {1'b1, 32'h55}) begin
            fails++;
            $display("FAIL nonzero_r1_b: got h=%b d=%h, expected h=1 d=55", r_hit_b, r_data_b);
        end
        stall = 1'b1;
        #2;
        rsn = 1'b0;
        exp_q.delete();
        #1;
        tests++;
        if (dut_outs !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h, expected 0", dut_outs);
        end
        tests++;
        if (r_outs !== '0) begin
            fails++;
            $display("FAIL async_reset_r1: got %h, expected 0", r_outs);
        end
        @(negedge clk);
        stall   = 1'b0;
        query_b = 5'd0;
        rsn     = 1'b1;
        tick();
        tests++;
        if ({count, o_valid} !== {3'd0, 1'b0}) begin
            fails++;
            $display("FAIL post_reset: got count=%0d v=%b, expected 0/0", count, o_valid);
        end
    endtask

    initial begin
        rsn      = 1'b0;
        in_valid = 1'b0;
        in_wr_en = 1'b0;
        in_data  = '0;
        in_addr  = '0;
        in_instr = '0;
        in_pc    = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        query_a  = '0;
        query_b  = '0;
        test_reset();
        test_single();
        test_pending_hit();
        test_youngest();
        test_stall();
        test_flush_stall();
        test_zero_reset();
        repeat (2) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
